thread_dispatch: RTL and testbench

THREAD_DISPATCH -- requirements
Module: thread_dispatch

---
 rtl/thread_dispatch_pkg.sv | 26 ++
 rtl/dispatch_fifo.sv | 55 +++++
 rtl/thread_dispatch.sv | 206 ++++++++++++++++++++
 tb/tb_thread_dispatch.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thread_dispatch_pkg.sv
// thread_dispatch_pkg: shared types and default constants for the thread
// dispatcher (FSM state encoding, operand-pair record, parameter defaults).
package thread_dispatch_pkg;

    // Dispatcher FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    // Width of one thread operand.
    localparam int OP_W = 8;

    // One queued job: operand for thread 1 in the upper byte, thread 2 below.
    typedef struct packed {
        logic [OP_W-1:0] data1;
        logic [OP_W-1:0] data2;
    } op_pair_t;

    localparam int PAIR_W                 = $bits(op_pair_t);
    localparam int DEFAULT_FIFO_DEPTH     = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/dispatch_fifo.sv
// dispatch_fifo: parameterised synchronous FIFO with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter. Head data is visible combinationally
// so the consumer can pop and capture in the same cycle.
module dispatch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Read/write pointer advance; push and pop in one cycle both take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/thread_dispatch.sv
// thread_dispatch: queues operand pairs and launches them one at a time on a
// two-thread stage, retiring each job once both threads report completion
// (rising edge of done1 and done2, in any order or together).
// Optional feature: define DISPATCH_TIMEOUT_EN to abort a job that waits
// TIMEOUT_CYCLES cycles without completing (sets sticky timeout_err).
module thread_dispatch
    import thread_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [OP_W-1:0] op_data1,
    input  logic [OP_W-1:0] op_data2,
    output logic            start,
    output logic [OP_W-1:0] in1,
    output logic [OP_W-1:0] in2,
    input  logic            done1,
    input  logic            done2,
    output logic            busy,
    output logic [7:0]      jobs_done,
    output logic            timeout_err
);
    // Reject configurations the queue pointers and timeout counter cannot represent.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 2)) begin : g_bad_config
        $error("thread_dispatch: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
    end

    state_t          r_state;
    state_t          w_state_next;
    op_pair_t        w_push_pair;
    op_pair_t        w_head_pair;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_start;
    logic            w_busy;
    logic [OP_W-1:0] r_in1;
    logic [OP_W-1:0] r_in2;
    logic [7:0]      r_jobs_done;
    logic            r_done1_prev;
    logic            r_done2_prev;
    logic            r_seen1;
    logic            r_seen2;
    logic            w_in_wait;
    logic            w_seen1_now;
    logic            w_seen2_now;
    logic            w_retire;
    logic            w_timeout;

    assign w_push_pair = '{data1: op_data1, data2: op_data2};
    assign w_push      = op_valid && !w_fifo_full;

    dispatch_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_pair),
        .i_pop   (w_pop),
        .o_data  (w_head_pair),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Completion tracking: an edge counts only while waiting; both seen -> retire.
    assign w_in_wait   = (r_state == ST_WAIT);
    assign w_seen1_now = r_seen1 || (done1 && !r_done1_prev);
    assign w_seen2_now = r_seen2 || (done2 && !r_done2_prev);
    assign w_retire    = w_in_wait && w_seen1_now && w_seen2_now;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int                TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]     TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_wait_cnt;
    logic          r_timeout_err;

    // Retirement takes priority over an abort landing in the same cycle.
    assign w_timeout   = w_in_wait && !w_retire && (r_wait_cnt == TIMEOUT_LAST);
    assign timeout_err = r_timeout_err;

    // WAIT-cycle counter, cleared in LAUNCH so it starts at 0 on WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_LAUNCH) begin
            r_wait_cnt <= '0;
        end else if (w_in_wait) begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
        end
    end

    // Sticky abort flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state and FSM-derived outputs.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_start      = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_start      = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_retire || w_timeout) begin
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Edge-detect history tracks the done inputs in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done1_prev <= 1'b0;
            r_done2_prev <= 1'b0;
        end else begin
            r_done1_prev <= done1;
            r_done2_prev <= done2;
        end
    end

    // Sticky seen flags, accumulated only in WAIT and cleared when the job ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen1 <= 1'b0;
            r_seen2 <= 1'b0;
        end else if (w_retire || w_timeout) begin
            r_seen1 <= 1'b0;
            r_seen2 <= 1'b0;
        end else if (w_in_wait) begin
            r_seen1 <= w_seen1_now;
            r_seen2 <= w_seen2_now;
        end
    end

    // Operand hold registers change only when a job is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in1 <= '0;
            r_in2 <= '0;
        end else if (w_pop) begin
            r_in1 <= w_head_pair.data1;
            r_in2 <= w_head_pair.data2;
        end
    end

    // Retired-job counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_jobs_done <= '0;
        end else if (w_retire) begin
            r_jobs_done <= r_jobs_done + 8'd1;
        end
    end

    assign op_ready  = !w_fifo_full;
    assign start     = w_start;
    assign busy      = w_busy;
    assign in1       = r_in1;
    assign in2       = r_in2;
    assign jobs_done = r_jobs_done;

endmodule

// File: tb/tb_thread_dispatch.sv
// tb_thread_dispatch: table-driven single-job vectors, directed corner-case
// sequences and randomized traffic checked against a transaction-level model
// (queue of accepted pairs, in-flight job with seen flags, retirement count).
module tb_thread_dispatch;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_data1;
    logic [7:0] op_data2;
    logic       start;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       done1;
    logic       done2;
    logic       busy;
    logic [7:0] jobs_done;
    logic       timeout_err;

    thread_dispatch #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_data1    (op_data1),
        .op_data2    (op_data2),
        .start       (start),
        .in1         (in1),
        .in2         (in2),
        .done1       (done1),
        .done2       (done2),
        .busy        (busy),
        .jobs_done   (jobs_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] mq[$];
    logic [15:0] m_cur;
    bit          m_waiting, m_in_launch, m_seen1, m_seen2, m_prev1, m_prev2, m_terr;
    int          m_wait_cnt;
    logic [7:0]  m_jobs;
    int          m_total;
    int          cyc;
    int          last_start;
    int          n_starts;

    typedef struct packed {
        bit         v;
        logic [7:0] a;
        logic [7:0] b;
        bit         d1;
        bit         d2;
        bit         e_start;
        bit         e_busy;
        bit         e_ready;
        logic [7:0] e_in1;
        logic [7:0] e_in2;
        logic [7:0] e_jobs;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cur       = '0;
        m_waiting   = 0;
        m_in_launch = 0;
        m_seen1     = 0;
        m_seen2     = 0;
        m_prev1     = 0;
        m_prev2     = 0;
        m_terr      = 0;
        m_wait_cnt  = 0;
        m_jobs      = 8'd0;
        m_total     = 0;
        last_start  = -100;
    endtask

    // One clock of stimulus; model updated from the specification's rules, outputs checked.
    task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b, input bit dn1, input bit dn2);
        bit          push_now;
        bit          r1;
        bit          r2;
        logic [15:0] pair;
        op_valid = v;
        op_data1 = a;
        op_data2 = b;
        done1    = dn1;
        done2    = dn2;
        push_now = v && (mq.size() < DEPTH);
        r1 = dn1 && !m_prev1;
        r2 = dn2 && !m_prev2;
        if (m_waiting) begin
            m_seen1 = m_seen1 | r1;
            m_seen2 = m_seen2 | r2;
            if (m_seen1 && m_seen2) begin
                m_jobs    = m_jobs + 8'd1;
                m_total++;
                m_waiting = 0;
                m_seen1   = 0;
                m_seen2   = 0;
            end
`ifdef DISPATCH_TIMEOUT_EN
            else if (m_wait_cnt == TMO - 1) begin
                m_terr    = 1;
                m_waiting = 0;
                m_seen1   = 0;
                m_seen2   = 0;
            end else begin
                m_wait_cnt++;
            end
`endif
        end
        m_prev1 = dn1;
        m_prev2 = dn2;
        @(posedge clk);
        #1;
        cyc++;
        if (m_in_launch) begin
            m_in_launch = 0;
            m_waiting   = 1;
            m_wait_cnt  = 0;
        end
        if (start === 1'b1) begin
            n_starts++;
            check("start_spacing_ge4", 32'(cyc - last_start >= 4), 1);
            check("start_while_job_active", 32'(m_waiting), 0);
            check("start_with_nonempty_queue", 32'(mq.size() != 0), 1);
            if (mq.size() != 0) begin
                pair  = mq.pop_front();
                m_cur = pair;
                check("launch_in1", in1, pair[15:8]);
                check("launch_in2", in2, pair[7:0]);
            end
            m_in_launch = 1;
            last_start  = cyc;
        end
        if (push_now) mq.push_back({a, b});
        check("op_ready", op_ready, 32'(mq.size() < DEPTH));
        check("jobs_done", jobs_done, m_jobs);
        check("timeout_err", timeout_err, 32'(m_terr));
        if (m_waiting || m_in_launch) check("busy_during_job", busy, 1);
        if (m_waiting) begin
            check("in1_hold", in1, m_cur[15:8]);
            check("in2_hold", in2, m_cur[7:0]);
        end
    endtask

    task automatic wait_start(input string name, input int budget, input bit dn1, input bit dn2);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            step(0, 8'h00, 8'h00, dn1, dn2);
            if (start === 1'b1) got = 1;
        end
        check(name, 32'(got), 1);
    endtask

    // Complete all outstanding work by toggling both done lines, then confirm idle.
    task automatic drain(input string name, input int budget);
        bit fin;
        fin = 0;
        for (int i = 0; i < budget && !fin; i++) begin
            if (mq.size() == 0 && !m_waiting && !m_in_launch) fin = 1;
            else step(0, 8'h00, 8'h00, i[0], i[0]);
        end
        check(name, 32'(fin), 1);
        step(0, 8'h00, 8'h00, 1'b0, 1'b0);
        step(0, 8'h00, 8'h00, 1'b0, 1'b0);
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_op_ready"}, op_ready, 1);
        check({tag, "_start"}, start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in1"}, in1, 0);
        check({tag, "_in2"}, in2, 0);
        check({tag, "_jobs_done"}, jobs_done, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          jobs_before;
        int          starts_before;
        int          acc;
        bit          t1;
        bit          t2;
        logic [7:0]  ra;
        logic [7:0]  rb;

        cyc      = 0;
        n_starts = 0;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_data1 = 8'h00;
        op_data2 = 8'h00;
        done1    = 1'b0;
        done2    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        rst_n = 1'b1;

        // Single job: done1 at LAUNCH+3, done2 at LAUNCH+4.
        //               v     a      b     d1 d2 st bs rd in1    in2    jobs
        tbl[0] = '{1'b1, 8'h05, 8'h03, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'd0};
        tbl[1] = '{1'b0, 8'h00, 8'h00, 0, 0, 1, 1, 1, 8'h05, 8'h03, 8'd0};
        tbl[2] = '{1'b0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 8'h05, 8'h03, 8'd0};
        tbl[3] = '{1'b0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 8'h05, 8'h03, 8'd0};
        tbl[4] = '{1'b0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 8'h05, 8'h03, 8'd0};
        tbl[5] = '{1'b0, 8'h00, 8'h00, 1, 0, 0, 1, 1, 8'h05, 8'h03, 8'd0};
        tbl[6] = '{1'b0, 8'h00, 8'h00, 1, 1, 0, 1, 1, 8'h05, 8'h03, 8'd1};
        tbl[7] = '{1'b0, 8'h00, 8'h00, 1, 1, 0, 0, 1, 8'h05, 8'h03, 8'd1};
        tbl[8] = '{1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h05, 8'h03, 8'd1};
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].d1, tbl[i].d2);
            check($sformatf("tbl%0d_start", i), start, tbl[i].e_start);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_ready", i), op_ready, tbl[i].e_ready);
            check($sformatf("tbl%0d_in1", i), in1, tbl[i].e_in1);
            check($sformatf("tbl%0d_in2", i), in2, tbl[i].e_in2);
            check($sformatf("tbl%0d_jobs", i), jobs_done, tbl[i].e_jobs);
        end

        // Simultaneous done edges retire in the same WAIT cycle.
        step(1, 8'hA1, 8'hB2, 0, 0);
        wait_start("simul_start", 6, 0, 0);
        step(0, 8'h00, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 1, 1);
        check("simul_jobs", jobs_done, 8'd2);
        check("simul_gap_busy", busy, 1);
        check("simul_gap_start", start, 0);
        step(0, 8'h00, 8'h00, 1, 1);
        check("simul_idle_busy", busy, 0);

        // Done levels held high from the prior job must not retire the next one.
        step(1, 8'hC3, 8'hD4, 1, 1);
        wait_start("level_start", 6, 1, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, 8'h00, 8'h00, 1, 1);
            check("level_no_retire", jobs_done, 8'd2);
        end
        step(0, 8'h00, 8'h00, 0, 0);
        check("level_fall_no_retire", jobs_done, 8'd2);
        step(0, 8'h00, 8'h00, 1, 1);
        check("level_retire", jobs_done, 8'd3);
        step(0, 8'h00, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 0, 0);

        // Back-to-back: fill behind a blocked job, then release it.
        starts_before = n_starts;
        step(1, 8'h10, 8'h20, 0, 0);
        wait_start("b2b_blocker_start", 6, 0, 0);
        step(0, 8'h00, 8'h00, 0, 0);
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            step(1, 8'h31 + 8'(k), 8'h41 + 8'(k), 0, 0);
            acc++;
        end
        check("b2b_full_after_4", op_ready, 0);
        step(1, 8'h35, 8'h45, 0, 0);
        check("b2b_stall", op_ready, 0);
        t1 = 0;
        for (int i = 0; i < 8 && !t1; i++) begin
            step(1, 8'h35, 8'h45, 1, 1);
            if (op_ready === 1'b1) t1 = 1;
        end
        check("b2b_ready_after_pop", 32'(t1), 1);
        step(1, 8'h35, 8'h45, 1, 1);
        step(0, 8'h00, 8'h00, 0, 0);
        drain("b2b_drain", 200);
        check("b2b_start_count", 32'(n_starts - starts_before), 6);
        check("b2b_jobs", jobs_done, 8'd9);

`ifdef DISPATCH_TIMEOUT_EN
        // Never complete thread 2: abort after TMO WAIT cycles, next job launches.
        step(1, 8'hE5, 8'hF6, 0, 0);
        step(1, 8'h11, 8'h22, 0, 0);
        check("tmo_launch", start, 1);
        jobs_before = int'(jobs_done);
        step(0, 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < TMO; i++) begin
            step(0, 8'h00, 8'h00, (i == 2), 0);
            if (i < TMO - 1) check("tmo_not_yet", timeout_err, 0);
            else             check("tmo_set", timeout_err, 1);
        end
        check("tmo_jobs_unchanged", jobs_done, 32'(jobs_before));
        wait_start("tmo_next_launch", 6, 0, 0);
        check("tmo_next_in1", in1, 8'h11);
        drain("tmo_drain", 200);
        check("tmo_sticky", timeout_err, 1);
`else
        // Without the timeout feature a stalled job waits indefinitely.
        step(1, 8'hE5, 8'hF6, 0, 0);
        wait_start("wait_forever_start", 6, 0, 0);
        for (int i = 0; i < 100; i++) step(0, 8'h00, 8'h00, 0, 0);
        check("wait_forever_busy", busy, 1);
        check("wait_forever_no_err", timeout_err, 0);
        drain("wait_forever_drain", 200);
`endif

        // Reset in WAIT with three entries queued discards everything.
        step(1, 8'h51, 8'h61, 0, 0);
        step(1, 8'h52, 8'h62, 0, 0);
        step(1, 8'h53, 8'h63, 0, 0);
        step(1, 8'h54, 8'h64, 0, 0);
        check("rst_mid_wait_busy", busy, 1);
        op_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("held_rst");
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(0, 8'h00, 8'h00, 0, 0);
            check("post_rst_no_start", start, 0);
            check("post_rst_busy", busy, 0);
        end
        step(1, 8'h66, 8'h77, 0, 0);
        wait_start("post_rst_new_start", 6, 0, 0);
        check("post_rst_in1", in1, 8'h66);
        drain("post_rst_drain", 100);

        // Randomized traffic against the model.
        t1 = 0;
        t2 = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) t1 = ~t1;
            if ($urandom_range(0, 3) == 0) t2 = ~t2;
            ra = 8'($urandom);
            rb = 8'($urandom);
            step(($urandom_range(0, 1) == 1), ra, rb, t1, t2);
        end
        drain("rand_drain", 400);

        // Sustained traffic long enough to wrap the job counter past 255.
        model_reset();
        #2;
        rst_n = 1'b0;
        op_valid = 1'b0;
        done1 = 1'b0;
        done2 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 1700; i++) begin
            ra = 8'($urandom);
            step(1, ra, ~ra, i[0], i[0]);
        end
        drain("wrap_drain", 200);
        check("wrap_count", jobs_done, 32'(m_total % 256));
        check("wrap_exceeded", 32'(m_total > 256), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
